dcache_mem_ctrl: RTL and testbench
==================================

DCACHE_MEM_CTRL -- requirements
Module: dcache_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default `DMEM_BLOCK_ADDR_SIZE, meaning block-address width.
REQ-002 SHALL have parameter BLOCK_W, default `DBLOCK_SIZE_BITS, meaning block data width.
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  in  1  cache miss/flush request present.
REQ-006 SHALL have port req_wb  in  1  write back victim block first.
REQ-007 SHALL have port req_fill  in  1  read fill block.
REQ-008 SHALL have ports req_wb_addr  in  ADDR_W  and  req_fill_addr  in  ADDR_W  block addresses.
REQ-009 SHALL have port req_wb_data  in  BLOCK_W  victim block data.
REQ-010 SHALL have port req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-011 SHALL have ports resp_valid  out  1  (one-cycle completion pulse) and resp_data  out  BLOCK_W  (fill data).
REQ-012 SHALL have ports mem_ren, mem_wen  out  1,  mem_addr  out  ADDR_W,  mem_din  out  BLOCK_W  (memory request side).
REQ-013 SHALL have ports mem_ready, mem_done  in  1,  mem_dout  in  BLOCK_W  (memory response side).

Function
REQ-014 SHALL implement states IDLE, WB, GAP, FILL, RESP.
REQ-015 IDLE: on accept, SHALL latch both addresses, wb data, req_wb and req_fill; go to WB if req_wb, else FILL if req_fill, else RESP.
REQ-016 WB: mem_wen=1, mem_ren=0, mem_addr=latched wb addr, mem_din=latched wb data, all held stable until mem_done is sampled high.
REQ-017 WB on mem_done: go to GAP if latched req_fill, else RESP.
REQ-018 GAP: SHALL hold mem_ren=mem_wen=0 for exactly one cycle, then go to FILL.
REQ-019 FILL: mem_ren=1, mem_wen=0, mem_addr=latched fill addr, held until mem_ready is sampled high.
REQ-020 FILL on mem_ready: SHALL capture mem_dout into resp_data in that same cycle, deassert mem_ren next cycle, and go to RESP.
REQ-021 RESP: resp_valid=1 for exactly one cycle, mem_ren=mem_wen=0, then IDLE; this guarantees at least one idle memory cycle between consecutive requests.
REQ-022 resp_data SHALL stay at the last captured fill value until the next fill capture; a write-only request leaves it unchanged.
REQ-023 mem_ren and mem_wen SHALL never be high in the same cycle.
REQ-024 mem_done during FILL or mem_ready during WB SHALL be ignored.
REQ-025 Latency: resp_valid SHALL rise exactly one cycle after the completing mem_done (write-only) or mem_ready (fill) is sampled.
REQ-026 req_valid with req_wb=req_fill=0 SHALL complete in RESP the cycle after accept, with no memory access.
REQ-027 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-028 Reset high SHALL immediately force IDLE, mem_ren=0, mem_wen=0, resp_valid=0, resp_data=0, mem_addr=0, mem_din=0, and all latches to 0.
REQ-029 Reset asserted mid-transaction SHALL abort it without completion pulse; after release req_ready=1 in the first cycle.

Structure
REQ-030 State encoding and the ADDR_W/BLOCK_W defaults SHALL come from the shared constants header (constants.vh).
REQ-031 SHALL be a single module with no sub-module; state register plus request latches only.

Verification
REQ-032 Fill only: req_fill_addr=0x05, memory returns 0xDEADBEEF -> mem_ren high until mem_ready, resp_data=0xDEADBEEF, resp_valid one cycle after mem_ready, mem_wen never high.
REQ-033 Writeback+fill: wb_addr=0x03, wb_data=0x12345678, fill_addr=0x07 -> write completes, exactly one cycle with both strobes low, then read; memory[0x03]=0x12345678 and resp_valid pulses once.
REQ-034 Write-only: req_wb=1, req_fill=0, wb_addr=0x0A -> resp_valid one cycle after mem_done, mem_ren never high, resp_data unchanged.
REQ-035 Back-to-back: two fills issued on consecutive IDLE cycles -> at least one cycle with mem_ren=0 between the two reads; both resp_data values correct.
REQ-036 Reset during FILL (mem_ren high, before mem_ready) -> mem_ren drops in the same cycle, no resp_valid, req_ready=1 after release.
REQ-037 All scenarios: assertion that mem_ren and mem_wen are never both high and that mem_addr/mem_din stay stable while a strobe is high.

Source files
------------

// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared constants for the data-cache memory controller.
// Holds the default block-address and block-data widths and the controller state encoding.
// Ports: none (package only).
package dcache_mem_ctrl_pkg;

  localparam int DMEM_BLOCK_ADDR_SIZE = 8;
  localparam int DBLOCK_SIZE_BITS     = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_GAP  = 3'd2,
    S_FILL = 3'd3,
    S_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_mem_ctrl.sv
// Data-cache miss/flush controller: optional victim writeback, then optional block fill.
// Latency: resp_valid one cycle after the completing mem_done/mem_ready; no-op request completes the cycle after accept.
// Backpressure: req_ready is high only in IDLE; memory strobes are held until mem_done (write) or mem_ready (read).
// Ports:
//   clock, reset                        - clock, async active-high reset
//   req_valid/req_ready, req_wb/req_fill,
//   req_wb_addr, req_fill_addr, req_wb_data - cache request side
//   resp_valid, resp_data               - completion pulse and fill data
//   mem_ren/mem_wen/mem_addr/mem_din    - memory command side
//   mem_ready/mem_done/mem_dout         - memory response side
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_W = DBLOCK_SIZE_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_wb,
  input  logic               req_fill,
  input  logic [ADDR_W-1:0]  req_wb_addr,
  input  logic [ADDR_W-1:0]  req_fill_addr,
  input  logic [BLOCK_W-1:0] req_wb_data,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [BLOCK_W-1:0] resp_data,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_din,
  input  logic               mem_ready,
  input  logic               mem_done,
  input  logic [BLOCK_W-1:0] mem_dout
);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wb_addr;
  logic [ADDR_W-1:0]  r_fill_addr;
  logic [BLOCK_W-1:0] r_wb_data;
  logic               r_req_wb;
  logic               r_req_fill;

  assign req_ready = (r_state == S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wb_addr   <= '0;
      r_fill_addr <= '0;
      r_wb_data   <= '0;
      r_req_wb    <= 1'b0;
      r_req_fill  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
    end else begin
      // Completion is a single-cycle pulse; only the transitions into RESP raise it.
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wb_addr   <= req_wb_addr;
            r_fill_addr <= req_fill_addr;
            r_wb_data   <= req_wb_data;
            r_req_wb    <= req_wb;
            r_req_fill  <= req_fill;
            // Strobes are registered, so the command is launched on the accept edge.
            if (req_wb) begin
              r_state  <= S_WB;
              mem_wen  <= 1'b1;
              mem_addr <= req_wb_addr;
              mem_din  <= req_wb_data;
            end else if (req_fill) begin
              r_state  <= S_FILL;
              mem_ren  <= 1'b1;
              mem_addr <= req_fill_addr;
            end else begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        S_WB: begin
          // Re-assert from the latches: same values as launched, so the bus stays stable.
          mem_addr <= r_wb_addr;
          mem_din  <= r_wb_data;
          // mem_ready is meaningless here and deliberately not looked at.
          if (mem_done && r_req_wb) begin
            mem_wen <= 1'b0;
            if (r_req_fill) begin
              r_state <= S_GAP;
            end else begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        S_GAP: begin
          // One dead cycle between the write and the read turnaround.
          r_state  <= S_FILL;
          mem_ren  <= 1'b1;
          mem_addr <= r_fill_addr;
        end
        S_FILL: begin
          mem_addr <= r_fill_addr;
          // mem_done is meaningless here and deliberately not looked at.
          if (mem_ready) begin
            resp_data  <= mem_dout;
            mem_ren    <= 1'b0;
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
module tb_dcache_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_wb, req_fill;
  logic [7:0]  req_wb_addr, req_fill_addr;
  logic [31:0] req_wb_data;
  logic        req_ready, resp_valid;
  logic [31:0] resp_data;
  logic        mem_ren, mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_ready, mem_done;
  logic [31:0] mem_dout;

  dcache_mem_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_wb       (req_wb),
    .req_fill     (req_fill),
    .req_wb_addr  (req_wb_addr),
    .req_fill_addr(req_fill_addr),
    .req_wb_data  (req_wb_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_ready    (mem_ready),
    .mem_done     (mem_done),
    .mem_dout     (mem_dout)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol properties checked across every scenario.
  a_excl: assert property (@(posedge clock) disable iff (reset) !(mem_ren && mem_wen))
    else begin viol++; $display("FAIL excl: mem_ren and mem_wen both high"); end
  a_stable: assert property (@(posedge clock) disable iff (reset)
      ((mem_ren && $past(mem_ren)) || (mem_wen && $past(mem_wen))) |-> ($stable(mem_addr) && $stable(mem_din)))
    else begin viol++; $display("FAIL stable: mem_addr/mem_din moved under strobe"); end

  // Memory model and monitor, both on the falling edge.
  logic [31:0] mem [256];
  int  lat   = 2;
  bit  noise = 1'b0;
  int  cyc   = 0;
  int  wcnt  = 0, rcnt = 0;
  int  n_resp, n_ren, n_wen;
  int  t_resp, t_pulse, t_ren_first, t_ren_last, t_wen_last, t_req;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (resp_valid) begin
      if (n_resp == 0) t_resp = cyc;
      n_resp++;
    end
    if (mem_ren) begin
      if (n_ren == 0) t_ren_first = cyc;
      t_ren_last = cyc;
      n_ren++;
    end
    if (mem_wen) begin
      t_wen_last = cyc;
      n_wen++;
    end
    mem_done  = 1'b0;
    mem_ready = 1'b0;
    if (mem_wen) begin
      if (wcnt == lat) begin
        mem_done = 1'b1; mem[mem_addr] = mem_din; t_pulse = cyc; wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
    if (mem_ren) begin
      if (rcnt == lat) begin
        mem_ready = 1'b1; mem_dout = mem[mem_addr]; t_pulse = cyc; rcnt = 0;
      end else rcnt++;
    end else rcnt = 0;
    // Out-of-phase handshakes the controller must ignore.
    if (noise && mem_ren) mem_done = 1'b1;
    if (noise && mem_wen) begin mem_ready = 1'b1; mem_dout = 32'hBAD0BAD0; end
  end

  task automatic clr();
    n_resp = 0; n_ren = 0; n_wen = 0;
    t_resp = -1; t_pulse = -100; t_ren_first = -1; t_ren_last = -1; t_wen_last = -1;
  endtask

  task automatic issue(input logic wb, input logic fill, input logic [7:0] wa,
                       input logic [7:0] fa, input logic [31:0] wd);
    @(negedge clock);
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    req_wb_addr = wa; req_fill_addr = fa; req_wb_data = wd;
    t_req = cyc;
    @(posedge clock); #1;
    req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int tail);
    int k = 0;
    while (n_resp == 0 && k < 100) begin @(posedge clock); k++; end
    if (n_resp == 0) chk({tag, "_timeout"}, 0, 1);
    repeat (tail) @(posedge clock);
  endtask

  logic [31:0] r1;
  int          last1;

  initial begin
    req_valid = 0; req_wb = 0; req_fill = 0;
    req_wb_addr = 0; req_fill_addr = 0; req_wb_data = 0;
    mem_ready = 0; mem_done = 0; mem_dout = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h05] = 32'hDEADBEEF;
    mem[8'h07] = 32'hCAFEF00D;
    mem[8'h11] = 32'h11112222;
    mem[8'h22] = 32'h33334444;
    clr();

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_ready", req_ready, 1);

    // Fill only, with a stray write request while busy
    lat = 2; clr();
    issue(0, 1, 8'h00, 8'h05, 32'h0);
    chk("fill_ready_busy", req_ready, 0);
    @(negedge clock);
    req_valid = 1; req_wb = 1; req_wb_addr = 8'h33; req_wb_data = 32'hFFFFFFFF;
    @(negedge clock);
    req_valid = 0; req_wb = 0;
    wait_resp("fill", 3);
    chk("fill_data", resp_data, 32'hDEADBEEF);
    chk("fill_npulse", n_resp, 1);
    chk("fill_lat", t_resp - t_pulse, 1);
    chk("fill_nwen", n_wen, 0);
    chk("fill_nren", n_ren, 3);
    chk("fill_stray_mem", mem[8'h33], 32'h0);

    // Writeback + fill with out-of-phase handshakes present
    lat = 1; noise = 1; clr();
    issue(1, 1, 8'h03, 8'h07, 32'h12345678);
    wait_resp("wbfill", 3);
    noise = 0;
    chk("wbfill_mem", mem[8'h03], 32'h12345678);
    chk("wbfill_data", resp_data, 32'hCAFEF00D);
    chk("wbfill_npulse", n_resp, 1);
    chk("wbfill_gap", t_ren_first - t_wen_last, 2);
    chk("wbfill_lat", t_resp - t_pulse, 1);
    chk("wbfill_nwen", n_wen, 2);

    // Write only
    lat = 3; clr();
    issue(1, 0, 8'h0A, 8'h44, 32'hA5A55A5A);
    wait_resp("wr", 3);
    chk("wr_mem", mem[8'h0A], 32'hA5A55A5A);
    chk("wr_nren", n_ren, 0);
    chk("wr_npulse", n_resp, 1);
    chk("wr_lat", t_resp - t_pulse, 1);
    chk("wr_data_kept", resp_data, 32'hCAFEF00D);
    chk("wr_nwen", n_wen, 4);

    // No-op request
    clr();
    issue(0, 0, 8'h01, 8'h02, 32'h55555555);
    wait_resp("noop", 3);
    chk("noop_lat", t_resp - t_req, 1);
    chk("noop_access", n_ren + n_wen, 0);
    chk("noop_npulse", n_resp, 1);
    chk("noop_data_kept", resp_data, 32'hCAFEF00D);

    // Back-to-back fills
    lat = 0; clr();
    issue(0, 1, 8'h00, 8'h11, 32'h0);
    wait_resp("b2b1", 0);
    r1 = resp_data; last1 = t_ren_last;
    clr();
    issue(0, 1, 8'h00, 8'h22, 32'h0);
    wait_resp("b2b2", 3);
    chk("b2b_data1", r1, 32'h11112222);
    chk("b2b_data2", resp_data, 32'h33334444);
    chk("b2b_idle_gap", (t_ren_first - last1) >= 2, 1);
    chk("b2b_npulse", n_resp, 1);

    // Reset in the middle of a fill
    lat = 10; clr();
    issue(0, 1, 8'h00, 8'h05, 32'h0);
    begin
      int k = 0;
      while (!mem_ren && k < 20) begin @(posedge clock); #1; k++; end
      if (!mem_ren) chk("rstfill_ren_timeout", 0, 1);
    end
    @(negedge clock); reset = 1'b1; #1;
    chk("rstfill_ren", mem_ren, 0);
    chk("rstfill_resp_valid", resp_valid, 0);
    chk("rstfill_addr", mem_addr, 0);
    chk("rstfill_resp_data", resp_data, 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("rstfill_ready", req_ready, 1);
    repeat (15) @(posedge clock);
    chk("rstfill_npulse", n_resp, 0);
    chk("rstfill_ren_after", mem_ren, 0);

    chk("protocol", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
